miner_read_scheduler: RTL
=========================

// Module: miner_read_scheduler
// PURPOSE
//  Shares one AXI4 read master among C_NUM_REQ job requesters (e.g. header/target loaders).
//  Round-robin arbitration latches each job's address and byte count and pulses ctrl_start into the master.
//  It then waits for ctrl_done and returns a per-requester completion pulse.
//  Sits between the miner job logic and the read master's ctrl_* port; at most one job is in flight.
// PARAMETERS
//  C_NUM_REQ          4        number of requesters (2..16)
//  C_M_AXI_ADDR_WIDTH 64       address width, must match the read master
//  C_XFER_SIZE_WIDTH  32       byte-count width, must match the read master
//  C_TIMEOUT_CYCLES   1048576  watchdog limit; used only with MINER_RD_TIMEOUT_EN
// PORTS
//  aclk            in   1                    clock; all logic on posedge
//  areset          in   1                    synchronous, active-high reset
//  req_valid       in   C_NUM_REQ            requester i has a job pending (level, held until req_ready)
//  req_ready       out  C_NUM_REQ            one-hot pulse, job of requester i accepted this cycle
//  req_addr        in   C_NUM_REQ*ADDR_W     packed start addresses, slice i = [i*ADDR_W +: ADDR_W]
//  req_size        in   C_NUM_REQ*XFER_W     packed byte counts, slice i
//  req_done        out  C_NUM_REQ            one-hot 1-cycle pulse, job of requester i finished
//  req_err         out  1                    qualifies req_done: job rejected or timed out
//  busy            out  1                    state != IDLE
//  cur_grant       out  $clog2(C_NUM_REQ)    index of the job in flight (valid while busy)
//  ctrl_start      out  1                    to read master, 1-cycle pulse
//  ctrl_done       in   1                    from read master, 1-cycle pulse
//  ctrl_addr_offset out ADDR_W               registered, stable from ctrl_start until ctrl_done
//  ctrl_xfer_size_in_bytes out XFER_W        registered, same stability rule
// BEHAVIOUR
//  Reset: state=IDLE; rr_ptr=0; all outputs 0, including ctrl_addr/size regs and cur_grant.
//  IDLE: if |req_valid, choose the first valid index at or after rr_ptr (wraps at C_NUM_REQ-1 -> 0).
//   - req_ready[g]=1 combinationally in the same cycle; latch addr/size/g; rr_ptr <= (g+1) mod C_NUM_REQ.
//   - size==0 -> REJECT; else -> START.
//  START: ctrl_start=1 for exactly this cycle -> WAIT.
//  WAIT: hold; on ctrl_done -> DONE. ctrl_done in any other state is ignored.
//  DONE: req_done[g]=1, req_err=0 -> IDLE. REJECT: req_done[g]=1, req_err=1, no ctrl_start -> IDLE.
//  Latency: accept at cycle 0 -> ctrl_start at cycle 1; ctrl_done at cycle n -> req_done at n+1.
//   - IDLE is always spent >=1 cycle, so the minimum job period is ctrl_done latency + 3 cycles.
//  Fairness: the just-granted index gets lowest priority next time; no requester waits more than
//   C_NUM_REQ-1 jobs.
//  req_valid dropped before ready: legal, no job taken. req_valid changes during busy: ignored until IDLE.
//  Simultaneous ctrl_done and areset: reset wins, no req_done.
//  Reset mid-job: the scheduler returns to IDLE; the read master must be reset in the same cycle.
//  No address alignment or size rounding here; the read master owns both.
// CONFIGURATION
//  MINER_RD_TIMEOUT_EN defined:
//   - a 32-bit wait counter clears in START and increments in WAIT.
//   - reaching C_TIMEOUT_CYCLES-1 without ctrl_done -> ERROR: req_done[g]=1 and req_err=1 for one cycle.
//   - the block then stays in ERROR with busy=1 and accepts nothing until areset, because the master
//     may still be mid-burst.
//  Not defined: no counter and no ERROR state; WAIT holds forever.
// STRUCTURE
//  Package miner_rd_sched_pkg:
//   - sched_state_t enum {IDLE, START, WAIT, DONE, REJECT, ERROR};
//   - function f_clog2_min1, giving a grant index width of at least 1.
//  Sub-module miner_rr_arbiter:
//   - combinational search: req vector + rr_ptr in -> one-hot grant + index + any_valid out.
//  The top holds the FSM, latch registers, round-robin pointer and optional watchdog.
// TESTING
//  1 Single job: req_valid[2]=1, addr=0x1000, size=256 -> req_ready[2] at T; ctrl_start at T+1 with
//    addr 0x1000 and size 256; ctrl_done at T+20 -> req_done[2] at T+21, req_err=0.
//  2 Round robin: all 4 requesters valid continuously -> grant order 0,1,2,3,0,1; each gets one
//    ctrl_start per round.
//  3 Zero size: req_size[1]=0 -> req_ready[1], then req_done[1]+req_err at the next cycle; no ctrl_start.
//  4 Spurious done: ctrl_done pulsed in IDLE and in START -> no state change and no req_done.
//  5 Reset mid-WAIT: areset for 1 cycle -> busy=0, all outputs 0 next cycle; a later ctrl_done is ignored.
//  6 Timeout: build with MINER_RD_TIMEOUT_EN and C_TIMEOUT_CYCLES=64, withhold ctrl_done ->
//    req_done+req_err after 64 WAIT cycles; busy stays 1 until areset.

Source files
------------

// File: rtl/miner_rd_sched_pkg.sv
// Shared types and helpers for the miner read scheduler.
// The optional watchdog build is selected with MINER_RD_TIMEOUT_EN.
package miner_rd_sched_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        WAIT   = 3'd2,
        DONE   = 3'd3,
        REJECT = 3'd4,
        ERROR  = 3'd5
    } sched_state_t;

    // Index width for a requester vector, never below one bit.
    function automatic int unsigned f_clog2_min1(input int unsigned n);
        return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/miner_rr_arbiter.sv
// Combinational round-robin search: first requester at or after the pointer,
// wrapping from C_NUM_REQ-1 back to 0.
module miner_rr_arbiter
    import miner_rd_sched_pkg::*;
#(
    parameter  int unsigned C_NUM_REQ = 4,
    localparam int unsigned IDX_W     = f_clog2_min1(C_NUM_REQ)
) (
    input  logic [C_NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]     i_rr_ptr,
    output logic [C_NUM_REQ-1:0] o_grant_oh,
    output logic [IDX_W-1:0]     o_grant_idx,
    output logic                 o_any_valid
);

    localparam int unsigned SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] w_sum;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        o_grant_oh  = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_sum       = '0;
        w_idx       = '0;
        for (int unsigned i = 0; i < C_NUM_REQ; i++) begin
            w_sum = {1'b0, i_rr_ptr} + SUM_W'(i);
            if (w_sum >= SUM_W'(C_NUM_REQ)) begin
                w_sum = w_sum - SUM_W'(C_NUM_REQ);
            end
            w_idx = w_sum[IDX_W-1:0];
            if (!w_found && i_req[w_idx]) begin
                w_found            = 1'b1;
                o_grant_idx        = w_idx;
                o_grant_oh[w_idx]  = 1'b1;
            end
        end
        o_any_valid = w_found;
    end

endmodule

// File: rtl/miner_read_scheduler.sv
// Shares one AXI4 read master among C_NUM_REQ job requesters, one job in flight.
// Define MINER_RD_TIMEOUT_EN to add the ctrl_done watchdog and the sticky ERROR state.
module miner_read_scheduler
    import miner_rd_sched_pkg::*;
#(
    parameter int unsigned C_NUM_REQ          = 4,
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
    parameter int unsigned C_XFER_SIZE_WIDTH  = 32,
    parameter int unsigned C_TIMEOUT_CYCLES   = 1048576
) (
    input  logic                                      aclk,
    input  logic                                      areset,
    input  logic [C_NUM_REQ-1:0]                      req_valid,
    output logic [C_NUM_REQ-1:0]                      req_ready,
    input  logic [C_NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0]   req_addr,
    input  logic [C_NUM_REQ*C_XFER_SIZE_WIDTH-1:0]    req_size,
    output logic [C_NUM_REQ-1:0]                      req_done,
    output logic                                      req_err,
    output logic                                      busy,
    output logic [f_clog2_min1(C_NUM_REQ)-1:0]        cur_grant,
    output logic                                      ctrl_start,
    input  logic                                      ctrl_done,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]             ctrl_addr_offset,
    output logic [C_XFER_SIZE_WIDTH-1:0]              ctrl_xfer_size_in_bytes
);

    localparam int unsigned IDX_W = f_clog2_min1(C_NUM_REQ);
    localparam int unsigned AW    = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned XW    = C_XFER_SIZE_WIDTH;

    if (C_NUM_REQ < 2 || C_NUM_REQ > 16 || C_TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("miner_read_scheduler: C_NUM_REQ must be 2..16 and C_TIMEOUT_CYCLES >= 2");
    end

    sched_state_t          r_state;
    sched_state_t          w_next_state;
    logic [IDX_W-1:0]      r_rr_ptr;
    logic [IDX_W-1:0]      r_grant;
    logic [IDX_W-1:0]      w_idx;
    logic [IDX_W-1:0]      w_fin_idx;
    logic [IDX_W-1:0]      w_ptr_next;
    logic [C_NUM_REQ-1:0]  w_grant_oh;
    logic [C_NUM_REQ-1:0]  r_req_done;
    logic                  w_any;
    logic                  w_accept;
    logic                  w_fin;
    logic                  w_fin_err;
    logic                  r_req_err;
    logic                  r_busy;
    logic                  r_ctrl_start;
    logic [AW-1:0]         r_addr;
    logic [XW-1:0]         r_size;
    logic [AW-1:0]         w_addr_arr [C_NUM_REQ];
    logic [XW-1:0]         w_size_arr [C_NUM_REQ];

    for (genvar i = 0; i < C_NUM_REQ; i++) begin : g_unpack
        assign w_addr_arr[i] = req_addr[i*AW +: AW];
        assign w_size_arr[i] = req_size[i*XW +: XW];
    end

    miner_rr_arbiter #(
        .C_NUM_REQ (C_NUM_REQ)
    ) u_arb (
        .i_req       (req_valid),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant_oh  (w_grant_oh),
        .o_grant_idx (w_idx),
        .o_any_valid (w_any)
    );

`ifdef MINER_RD_TIMEOUT_EN
    logic [31:0] r_wait_cnt;

    // Counts WAIT cycles of the current job; restarted by START.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wait_cnt <= '0;
        end else if (r_state == START) begin
            r_wait_cnt <= '0;
        end else if (r_state == WAIT) begin
            r_wait_cnt <= r_wait_cnt + 32'd1;
        end
    end
`endif

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // w_fin marks the cycle that decides a job's completion; its pulse is registered below.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_fin        = 1'b0;
        w_fin_err    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_accept = 1'b1;
                    if (w_size_arr[w_idx] == '0) begin
                        w_next_state = REJECT;
                        w_fin        = 1'b1;
                        w_fin_err    = 1'b1;
                    end else begin
                        w_next_state = START;
                    end
                end
            end
            START: w_next_state = WAIT;
            WAIT: begin
                if (ctrl_done) begin
                    w_next_state = DONE;
                    w_fin        = 1'b1;
                end
`ifdef MINER_RD_TIMEOUT_EN
                else if (r_wait_cnt == 32'(C_TIMEOUT_CYCLES - 1)) begin
                    w_next_state = ERROR;
                    w_fin        = 1'b1;
                    w_fin_err    = 1'b1;
                end
`endif
            end
            DONE:   w_next_state = IDLE;
            REJECT: w_next_state = IDLE;
`ifdef MINER_RD_TIMEOUT_EN
            ERROR:  w_next_state = ERROR;
`endif
            default: w_next_state = IDLE;
        endcase
    end

    assign w_fin_idx  = w_accept ? w_idx : r_grant;
    assign w_ptr_next = (w_idx == IDX_W'(C_NUM_REQ - 1)) ? '0 : w_idx + IDX_W'(1);

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_rr_ptr     <= '0;
            r_grant      <= '0;
            r_addr       <= '0;
            r_size       <= '0;
            r_busy       <= 1'b0;
            r_ctrl_start <= 1'b0;
            r_req_done   <= '0;
            r_req_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rr_ptr <= w_ptr_next;
                r_grant  <= w_idx;
                r_addr   <= w_addr_arr[w_idx];
                r_size   <= w_size_arr[w_idx];
            end
            r_busy       <= (w_next_state != IDLE);
            r_ctrl_start <= (w_next_state == START);
            r_req_done   <= w_fin ? (C_NUM_REQ'(1) << w_fin_idx) : '0;
            r_req_err    <= w_fin_err;
        end
    end

    assign req_ready               = w_accept ? w_grant_oh : '0;
    assign req_done                = r_req_done;
    assign req_err                 = r_req_err;
    assign busy                    = r_busy;
    assign cur_grant               = r_grant;
    assign ctrl_start              = r_ctrl_start;
    assign ctrl_addr_offset        = r_addr;
    assign ctrl_xfer_size_in_bytes = r_size;

endmodule
